// File: rtl/boton_antirrebote_if.sv
`default_nettype none
// ============================================================================
// boton_antirrebote_if : push-button pad in, debounced level/strobes out
// Rev 1.0
// ============================================================================
interface boton_antirrebote_if #(
   parameter int BNC_W = 8
);
   logic             Btn_raw;
   logic             OP;
   logic             OP_rise;
   logic             OP_fall;
   logic [BNC_W-1:0] Bounce_cnt;

   // master: pad/driver side; slave: the debouncer
   modport master (output Btn_raw, input OP, OP_rise, OP_fall, Bounce_cnt);
   modport slave  (input Btn_raw, output OP, OP_rise, OP_fall, Bounce_cnt);
endinterface
`default_nettype wire

// File: rtl/boton_antirrebote.sv
`default_nettype none
// ============================================================================
// boton_antirrebote : 2-flop synchroniser + stability-check debouncer with strobes
// Rev 1.0
// ============================================================================
module boton_antirrebote #(
   parameter int STABLE_CYCLES = 50000,
   parameter int CNT_W         = 16,
   parameter int BNC_W         = 8
) (
   input  wire logic          Clk,
   input  wire logic          Rst_n,
   boton_antirrebote_if.slave bus
);

   typedef enum logic [1:0] {
      ST_LOW    = 2'd0,
      ST_CHK_HI = 2'd1,
      ST_HIGH   = 2'd2,
      ST_CHK_LO = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [BNC_W-1:0] C_BNC_MAX  = {BNC_W{1'b1}};

   state_t           state_q;
   logic             s1_q;
   logic             s2_q;
   logic [CNT_W-1:0] cnt_q;
   logic [BNC_W-1:0] bnc_q;
   logic             op_q;
   logic             rise_q;
   logic             fall_q;

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q <= ST_LOW;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         cnt_q   <= '0;
         bnc_q   <= '0;
         op_q    <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         s1_q   <= bus.Btn_raw;
         s2_q   <= s1_q;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         unique case (state_q)
            ST_LOW: begin
               if (s2_q) begin
                  state_q <= ST_CHK_HI;
                  cnt_q   <= '0;
               end
            end
            ST_CHK_HI: begin
               // a glitch back to 0 aborts the check and is tallied as a bounce
               if (!s2_q) begin
                  state_q <= ST_LOW;
                  cnt_q   <= '0;
                  if (bnc_q != C_BNC_MAX) bnc_q <= bnc_q + BNC_W'(1);
               end else if (cnt_q == C_LAST_CNT) begin
                  state_q <= ST_HIGH;
                  cnt_q   <= '0;
                  op_q    <= 1'b1;
                  rise_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_HIGH: begin
               if (!s2_q) begin
                  state_q <= ST_CHK_LO;
                  cnt_q   <= '0;
               end
            end
            ST_CHK_LO: begin
               if (s2_q) begin
                  state_q <= ST_HIGH;
                  cnt_q   <= '0;
                  if (bnc_q != C_BNC_MAX) bnc_q <= bnc_q + BNC_W'(1);
               end else if (cnt_q == C_LAST_CNT) begin
                  state_q <= ST_LOW;
                  cnt_q   <= '0;
                  op_q    <= 1'b0;
                  fall_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_LOW;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign bus.OP         = op_q;
   assign bus.OP_rise    = rise_q;
   assign bus.OP_fall    = fall_q;
   assign bus.Bounce_cnt = bnc_q;

endmodule
`default_nettype wire

// File: tb/tb_boton_antirrebote.sv
`default_nettype none
// ============================================================================
// tb_boton_antirrebote : directed stimulus, strobe scoreboard, STABLE_CYCLES=4
// Rev 1.0
// ============================================================================
module tb_boton_antirrebote;

   logic Clk   = 1'b0;
   logic Rst_n = 1'b0;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   typedef struct {
      bit rise;
      int edge_n;
      int bnc;
   } exp_t;

   exp_t sb[$];

   boton_antirrebote_if #(.BNC_W(8)) bus ();
   boton_antirrebote_if #(.BNC_W(2)) bus2 ();

   boton_antirrebote #(.STABLE_CYCLES(4), .CNT_W(3), .BNC_W(8)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   boton_antirrebote #(.STABLE_CYCLES(4), .CNT_W(3), .BNC_W(2)) dut_sat (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus2)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic nedge(input int n);
      repeat (n) @(negedge Clk);
   endtask

   // monitor: every strobe from the main DUT must match the next scoreboard entry
   always @(negedge Clk) begin
      exp_t e;
      if (bus.OP_rise || bus.OP_fall) begin
         if (bus.OP_rise && bus.OP_fall)
            chk("strobes_both_high", 1, 0);
         if (sb.size() == 0) begin
            chk("unexpected_strobe", int'(bus.OP_rise) * 2 + int'(bus.OP_fall), 0);
         end else begin
            e = sb.pop_front();
            chk("strobe_kind_rise", int'(bus.OP_rise), int'(e.rise));
            chk("strobe_edge", cyc, e.edge_n);
            chk("strobe_op_level", int'(bus.OP), int'(e.rise));
            chk("strobe_bounce_cnt", int'(bus.Bounce_cnt), e.bnc);
         end
      end
      if (bus2.OP_rise || bus2.OP_fall)
         chk("sat_dut_unexpected_strobe", 1, 0);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: edge %0d reached without completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int sat_exp[5];
      sat_exp = '{1, 2, 3, 3, 3};

      bus.Btn_raw  = 1'b0;
      bus2.Btn_raw = 1'b0;
      Rst_n        = 1'b0;
      nedge(2);

      // reset held with the button pressed
      bus.Btn_raw = 1'b1;
      repeat (2) begin
         nedge(1);
         chk("rst_op", int'(bus.OP), 0);
         chk("rst_rise", int'(bus.OP_rise), 0);
         chk("rst_fall", int'(bus.OP_fall), 0);
         chk("rst_bnc", int'(bus.Bounce_cnt), 0);
      end

      // stuck-pressed button; reset pulse at edge 5 restarts the check
      c     = cyc;
      Rst_n = 1'b1;
      nedge(4);
      Rst_n = 1'b0;
      nedge(1);
      chk("midrst_op", int'(bus.OP), 0);
      chk("midrst_rise", int'(bus.OP_rise), 0);
      Rst_n = 1'b1;
      sb.push_back('{rise: 1'b1, edge_n: c + 12, bnc: 0});
      nedge(2);
      chk("midrst_op_edge7", int'(bus.OP), 0);
      nedge(4);
      chk("midrst_op_before_rise", int'(bus.OP), 0);
      nedge(2);
      chk("midrst_op_after_rise", int'(bus.OP), 1);
      chk("midrst_rise_single", int'(bus.OP_rise), 0);

      // clean release
      c           = cyc;
      bus.Btn_raw = 1'b0;
      sb.push_back('{rise: 1'b0, edge_n: c + 7, bnc: 0});
      nedge(6);
      chk("release_op_edge6", int'(bus.OP), 1);
      nedge(2);
      chk("release_op_edge8", int'(bus.OP), 0);
      chk("release_fall_edge8", int'(bus.OP_fall), 0);

      // clean press
      c           = cyc;
      bus.Btn_raw = 1'b1;
      sb.push_back('{rise: 1'b1, edge_n: c + 7, bnc: 0});
      nedge(6);
      chk("press_op_edge6", int'(bus.OP), 0);
      nedge(1);
      chk("press_op_edge7", int'(bus.OP), 1);
      chk("press_rise_edge7", int'(bus.OP_rise), 1);
      nedge(1);
      chk("press_rise_edge8", int'(bus.OP_rise), 0);
      chk("press_op_edge8", int'(bus.OP), 1);

      c           = cyc;
      bus.Btn_raw = 1'b0;
      sb.push_back('{rise: 1'b0, edge_n: c + 7, bnc: 0});
      nedge(9);

      // bouncy press 1,0,1,0 then 1 held: two aborted checks
      c           = cyc;
      bus.Btn_raw = 1'b1;
      nedge(1);
      bus.Btn_raw = 1'b0;
      nedge(1);
      bus.Btn_raw = 1'b1;
      nedge(1);
      bus.Btn_raw = 1'b0;
      nedge(1);
      bus.Btn_raw = 1'b1;
      sb.push_back('{rise: 1'b1, edge_n: c + 11, bnc: 2});
      nedge(6);
      chk("bouncy_op_before", int'(bus.OP), 0);
      chk("bouncy_bnc", int'(bus.Bounce_cnt), 2);
      nedge(2);
      chk("bouncy_op_after", int'(bus.OP), 1);
      chk("bouncy_bnc_after", int'(bus.Bounce_cnt), 2);
      nedge(4);

      // saturation on the 2-bit bounce counter
      for (int i = 0; i < 5; i++) begin
         bus2.Btn_raw = 1'b1;
         nedge(1);
         bus2.Btn_raw = 1'b0;
         nedge(3);
         chk($sformatf("sat_bnc_%0d", i), int'(bus2.Bounce_cnt), sat_exp[i]);
      end
      chk("sat_op", int'(bus2.OP), 0);

      nedge(10);
      chk("scoreboard_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
